// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Drives the register file's single write port (D, DA, RW). Single-cycle ALU
// results are written the edge after they are presented. Long-latency results
// are buffered in a small FIFO and written when the ALU leaves the write port
// free. A busy-bit scoreboard tracks destinations reserved at issue. Each bit
// clears when the matching long-latency result is popped for writeback.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   alu_valid/rd/data     ALU result, always accepted (no backpressure)
//   mem_valid/rd/data     long-latency result offered to the FIFO
//   mem_ready             FIFO has room (count < DEPTH)
//   rsv_valid/rsv_rd      issue reserves a long-latency destination
//   busy[31:0]            scoreboard; busy[0] is always 0
//   D, DA, RW             registered register-file write port
//   fifo_count            FIFO occupancy
//
// Handshake: a long-latency result transfers on the rising edge where
// mem_valid && mem_ready. The producer holds mem_rd/mem_data stable while
// mem_valid is high and mem_ready is low. mem_ready depends only on the
// registered count, so there is no combinational path from mem_valid.
// The ALU side has no handshake; a valid ALU result is consumed every cycle.
// -----------------------------------------------------------------------------
module writeback_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  input  logic                     rsv_valid,
  input  logic [4:0]               rsv_rd,
  output logic [31:0]              busy,
  output logic [XLEN-1:0]          D,
  output logic [4:0]               DA,
  output logic                     RW,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // FIFO storage and pointers. DEPTH is a power of two, so the pointers
  // wrap naturally at AW bits.
  logic [4:0]      r_fifo_rd   [DEPTH];
  logic [XLEN-1:0] r_fifo_data [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic [31:0]     r_busy;
  logic [XLEN-1:0] r_d;
  logic [4:0]      r_da;
  logic            r_rw;

  logic            w_push;
  logic            w_pop;
  logic            w_alu_win;
  logic            w_empty;
  logic [4:0]      w_head_rd;
  logic [XLEN-1:0] w_head_data;
  logic [31:0]     w_busy_next;

  assign mem_ready   = (r_count < DEPTH_C);
  assign w_empty     = (r_count == '0);
  assign w_push      = mem_valid && mem_ready;
  // An ALU result aimed at x0 is dropped and leaves the port to the FIFO.
  assign w_alu_win   = alu_valid && (alu_rd != 5'd0);
  assign w_pop       = !w_alu_win && !w_empty;
  assign w_head_rd   = r_fifo_rd[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  // Scoreboard update. The set is applied after the clear, so a reservation
  // and a retirement of the same register on one edge leave the bit set.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop) begin
      w_busy_next[w_head_rd] = 1'b0;
    end
    if (rsv_valid && (rsv_rd != 5'd0)) begin
      w_busy_next[rsv_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // FIFO payload needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= mem_rd;
      r_fifo_data[r_wptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Write-port arbitration. ALU first, then the FIFO head. D and DA hold
  // their values when there is nothing to write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d  <= '0;
      r_da <= '0;
      r_rw <= 1'b0;
    end else if (w_alu_win) begin
      r_d  <= alu_data;
      r_da <= alu_rd;
      r_rw <= 1'b1;
    end else if (w_pop) begin
      r_d  <= w_head_data;
      r_da <= w_head_rd;
      // A popped entry for x0 is discarded without a write.
      r_rw <= (w_head_rd != 5'd0);
    end else begin
      r_rw <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign busy       = r_busy;
  assign D          = r_d;
  assign DA         = r_da;
  assign RW         = r_rw;
  assign fifo_count = r_count;

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage driving the register file's single write port (D, DA, RW). Merges single-cycle ALU results with long-latency memory/multiply results, which are buffered in a small FIFO. Grants at most one register write per cycle and keeps a busy-bit scoreboard of destinations reserved by issue. Sits between the execute/memory stages and the register file. The register file's write-to-read bypass makes a write visible to operand reads in the same cycle RW is high.

## Interface
- XLEN, 32: data width.
- DEPTH, 2: memory-result FIFO entries (power of two, ≥2).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- alu_valid  in  1  ALU result present this cycle; always accepted, no backpressure.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- mem_valid  in  1  long-latency result offered.
- mem_ready  out  1  FIFO can accept; `count < DEPTH`; combinational from count only.
- mem_rd  in  5  long-latency destination.
- mem_data  in  XLEN  long-latency result.
- rsv_valid  in  1  issue reserves a long-latency destination.
- rsv_rd  in  5  reserved register.
- busy  out  32  scoreboard; bit i = register i awaiting long-latency write; busy[0] constant 0.
- D  out  XLEN  register-file write data (registered).
- DA  out  5  register-file write address (registered).
- RW  out  1  register-file write enable (registered).
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Push:** on `mem_valid && mem_ready`, {mem_rd, mem_data} is pushed at the clock edge.
- **Arbitration, each edge, priority order:**
  1. `alu_valid && alu_rd != 0`: D <= alu_data, DA <= alu_rd, RW <= 1. FIFO holds.
  2. Else if FIFO not empty: pop head; D/DA <= head data/rd.
     - RW <= 1 if head rd != 0.
     - Head rd == 0: entry is discarded and RW <= 0.
  3. Else: RW <= 0; D and DA hold their previous values.
- **x0 handling:** an ALU result with alu_rd = 0 is dropped and does not consume the slot, so the FIFO may drain in that cycle.
- **FIFO access:** push and pop in the same cycle are legal.
  - Count is unchanged.
  - A push into a full FIFO cannot occur, since mem_ready = 0.
  - Read and write pointers wrap modulo DEPTH.
- **Ordering:** FIFO entries retire strictly in push order.
- **Scoreboard set:** `rsv_valid && rsv_rd != 0` sets busy[rsv_rd] at the edge.
- **Scoreboard clear:** popping an entry clears busy[head rd] at the same edge RW rises.
- **Scoreboard conflict:** set and clear of the same register at the same edge leaves the bit 1 (set wins).
- **ALU writes** never touch busy.
- **Not checked by this block:** issue guarantees no ALU write to a busy register.

## Timing
- **Reset** (asynchronous, immediate on rst_n low):
  - RW = 0, D = 0, DA = 0.
  - busy = 0, fifo_count = 0, mem_ready = 1.
  - FIFO contents are discarded. Reset mid-operation loses in-flight results and reservations.
- **ALU latency:** 1 edge. alu_valid sampled at edge N gives RW = 1 during cycle N..N+1.
- **Memory latency:** minimum 2 edges (push at N, pop at N+1). Further delayed by one edge per contending ALU write.
- **Starvation:** a continuous ALU stream starves the FIFO. mem_ready falls once count = DEPTH; the producer holds mem_valid/rd/data stable until accepted.
- **Pulse width:** RW is high for exactly one cycle per write. Back-to-back writes give consecutive RW-high cycles with new D/DA each cycle.

## Test plan
- **Reset:**
  - Stimulus: assert rst_n = 0 mid-stream with FIFO count 2 and busy[7] = 1.
  - Required: RW = 0, fifo_count = 0, busy = 0, mem_ready = 1 immediately, with no clock edge.
- **ALU write:**
  - Stimulus: alu_valid = 1, alu_rd = 5, alu_data = 0x00001234 for one cycle.
  - Required: after the next edge, RW = 1, DA = 5, D = 0x00001234 for one cycle; then RW = 0.
- **Contention:**
  - Stimulus: rsv_rd = 7, then a memory result {rd = 7, 0xCAFEF00D} is pushed. On the following cycle, ALU {rd = 3, 0x11}.
  - Required: ALU write DA = 3 first. Next cycle DA = 7, D = 0xCAFEF00D, and busy[7] clears on that edge.
- **Full FIFO:**
  - Stimulus: ALU valid every cycle with rd = 1; three memory results offered (rd 8, 9, 10).
  - Required: mem_ready = 0 after two pushes; rd 10 is held. When ALU stops, writes go DA = 8, 9, 10 on consecutive cycles.
- **x0:**
  - Stimulus: FIFO holds rd = 4 while alu_valid = 1, alu_rd = 0.
  - Required: the rd = 4 entry is written that edge. A popped entry with rd = 0 gives RW = 0 and decrements count.
- **Scoreboard collision:**
  - Stimulus: rsv_rd = 6 issued at the same edge a popped entry with rd = 6 is written.
  - Required: RW = 1, DA = 6, and busy[6] remains 1.
